// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// LOADER_CHECKSUM_EN adds the CHECK state used for the trailing checksum byte.
package loader_pkg;

  localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
  localparam int          WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/instr_mem_loader.sv
// Assembles a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional macro LOADER_CHECKSUM_EN: after the halt word, a trailing XOR checksum byte is verified.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int CELDAS = 160,
  parameter int NBYTE  = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [NBYTE-1:0] i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_wr_en,
  output logic [NBITS-1:0] o_wr_addr,
  output logic [NBITS-1:0] o_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [NBITS-1:0] o_word_count,
  output state_t           o_state
);

  // Byte stream handshake: a byte is consumed in any cycle where i_rx_valid is high
  // and the loader is in RECV or WRITE (or CHECK for the checksum byte); there is no
  // backpressure, so the sender may present one byte every cycle.

  state_t                   state_q, state_d;
  logic [NBITS-1:0]         addr_q;
  logic [1:0]               cnt_q;
  logic [NBITS-NBYTE-1:0]   shift_q;
  logic [NBITS-1:0]         wr_addr_q;
  logic [NBITS-1:0]         wr_data_q;
  logic [NBITS-1:0]         count_q;
`ifdef LOADER_CHECKSUM_EN
  logic [NBYTE-1:0]         csum_q;
`endif

  logic byte_take;
  logic word_full;
  logic new_load;
  logic is_halt;
  logic last_slot;

  always_comb begin
    byte_take = i_rx_valid && (state_q == S_RECV || state_q == S_WRITE);
    // A byte seen during WRITE always lands in slot 0, so only RECV can complete a word.
    word_full = byte_take && (state_q == S_RECV) && (cnt_q == 2'd3);
    new_load  = i_start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    is_halt   = (wr_data_q == NBITS'(HALT_WORD));
    last_slot = (wr_addr_q == NBITS'(CELDAS - WORD_BYTES));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (i_start) state_d = S_RECV;
      S_RECV:                  if (word_full) state_d = S_WRITE;
      S_WRITE: begin
        if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (last_slot) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (i_rx_valid) state_d = (i_rx_data == csum_q) ? S_DONE : S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (new_load) begin
        addr_q  <= '0;
        cnt_q   <= '0;
        shift_q <= '0;
        count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q  <= '0;
`endif
      end else begin
        if (byte_take) begin
          shift_q <= {shift_q[NBITS-2*NBYTE-1:0], i_rx_data};
          cnt_q   <= cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_q  <= csum_q ^ i_rx_data;
`endif
        end
        // Write address/data are latched separately so a byte arriving during WRITE
        // cannot disturb them while the strobe is high.
        if (word_full) begin
          wr_data_q <= {shift_q, i_rx_data};
          wr_addr_q <= addr_q;
        end
        if (state_q == S_WRITE) begin
          addr_q  <= addr_q + NBITS'(WORD_BYTES);
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_wr_en      = (state_q == S_WRITE) && !i_reset;
    o_wr_addr    = wr_addr_q;
    o_wr_data    = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
    o_busy       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
    o_busy       = (state_q == S_RECV) || (state_q == S_WRITE);
`endif
    o_done       = (state_q == S_DONE);
    o_error      = (state_q == S_ERROR);
    o_word_count = count_q;
    o_state      = state_q;
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (CELDAS=16 so overflow is reachable quickly).
// Build with LOADER_CHECKSUM_EN to also exercise the trailing checksum byte.
module tb_instr_mem_loader;
  import loader_pkg::*;

  localparam int NBITS  = 32;
  localparam int CELDAS = 16;
  localparam int NBYTE  = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [NBYTE-1:0] rx_data;
  logic             rx_valid;
  logic             wr_en;
  logic [NBITS-1:0] wr_addr;
  logic [NBITS-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             error;
  logic [NBITS-1:0] word_count;
  state_t           st;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  tb_xor;

  instr_mem_loader #(.NBITS(NBITS), .CELDAS(CELDAS), .NBYTE(NBYTE)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_word_count (word_count),
    .o_state      (st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%h@%h expected=none", wr_data, wr_addr);
      end
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({wr_addr, wr_data} === e) else begin
          failures++;
          $error("FAIL write observed=%h@%h expected=%h@%h", wr_data, wr_addr, e[31:0], e[63:32]);
        end
      end
    end
  end

  // driver tasks: inputs change on the falling edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    tb_xor   = tb_xor ^ b;
  endtask

  task automatic idle();
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    rx_valid = 1'b0;
    tb_xor   = 8'h00;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // ends a load after the halt word; with checksum the trailer follows the CHECK entry
  task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = tb_xor;
    idle();
    idle();
    send(x);
`endif
    idle();
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({tag, "_timeout"}, 32'(n < 20), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tb_xor   = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_count", word_count, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_state", 32'(st), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // normal load: 0022_0820 then halt, halt bytes back-to-back with the first WRITE
    pulse_start();
    #1;
    check("norm_busy", 32'(busy), 32'd1);
    expect_write(32'd0, 32'h0022_0820);
    expect_write(32'd4, 32'hFFFF_FFFF);
    send_word(32'h0022_0820);
    send_word(32'hFFFF_FFFF);
    finish_load();
    wait_end("norm");
    check("norm_done", 32'(done), 32'd1);
    check("norm_error", 32'(error), 32'd0);
    check("norm_busy_end", 32'(busy), 32'd0);
    check("norm_count", word_count, 32'd2);
    check("norm_pending", 32'(exp_q.size()), 32'd0);

    // bytes in DONE are ignored
    send_word(32'h1234_5678);
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("done_ignore_count", word_count, 32'd2);
    check("done_ignore_done", 32'(done), 32'd1);

    // back-to-back 01..08
    pulse_start();
    #1;
    check("b2b_done_cleared", 32'(done), 32'd0);
    expect_write(32'd0, 32'h0102_0304);
    expect_write(32'd4, 32'h0506_0708);
    for (int i = 1; i <= 8; i++) send(8'(i));
    idle();
    repeat (3) @(negedge clk);
    #1;
    check("b2b_count", word_count, 32'd2);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_hold_addr", wr_addr, 32'd4);
    check("b2b_hold_data", wr_data, 32'h0506_0708);
    check("b2b_pending", 32'(exp_q.size()), 32'd0);
    expect_write(32'd8, 32'hFFFF_FFFF);
    send_word(32'hFFFF_FFFF);
    finish_load();
    wait_end("b2b");
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_count_end", word_count, 32'd3);

    // start pulse in RECV must not realign the word
    pulse_start();
    expect_write(32'd0, 32'hAABB_CCDD);
    expect_write(32'd4, 32'hFFFF_FFFF);
    send(8'hAA);
    send(8'hBB);
    @(negedge clk);
    start    = 1'b1;
    rx_valid = 1'b0;
    send(8'hCC);
    send(8'hDD);
    send_word(32'hFFFF_FFFF);
    finish_load();
    wait_end("recv_start");
    check("recv_start_done", 32'(done), 32'd1);
    check("recv_start_count", word_count, 32'd2);

    // overflow: four non-halt words fill CELDAS=16
    pulse_start();
    expect_write(32'd0,  32'h1011_1213);
    expect_write(32'd4,  32'h2021_2223);
    expect_write(32'd8,  32'h3031_3233);
    expect_write(32'd12, 32'h4041_4243);
    send_word(32'h1011_1213);
    send_word(32'h2021_2223);
    send_word(32'h3031_3233);
    send_word(32'h4041_4243);
    idle();
    wait_end("ovf");
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_done", 32'(done), 32'd0);
    check("ovf_busy", 32'(busy), 32'd0);
    check("ovf_count", word_count, 32'd4);
    check("ovf_last_addr", wr_addr, 32'd12);

    // reset mid-word, then restart from address 0
    pulse_start();
    #1;
    check("rmw_error_cleared", 32'(error), 32'd0);
    check("rmw_count_cleared", word_count, 32'd0);
    send(8'h5A);
    send(8'h5B);
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmw_wr_en", 32'(wr_en), 32'd0);
    check("rmw_busy", 32'(busy), 32'd0);
    check("rmw_done", 32'(done), 32'd0);
    check("rmw_error", 32'(error), 32'd0);
    check("rmw_count", word_count, 32'd0);
    check("rmw_wr_addr", wr_addr, 32'd0);
    check("rmw_wr_data", wr_data, 32'd0);
    check("rmw_state", 32'(st), 32'(S_IDLE));
    pulse_start();
    expect_write(32'd0, 32'hC0C1_C2C3);
    expect_write(32'd4, 32'hFFFF_FFFF);
    send_word(32'hC0C1_C2C3);
    send_word(32'hFFFF_FFFF);
    finish_load();
    wait_end("rmw");
    check("rmw_reload_done", 32'(done), 32'd1);
    check("rmw_reload_count", word_count, 32'd2);

`ifdef LOADER_CHECKSUM_EN
    // checksum: 11^22^33^44^FF^FF^FF^FF = 44
    pulse_start();
    expect_write(32'd0, 32'h1122_3344);
    expect_write(32'd4, 32'hFFFF_FFFF);
    send_word(32'h1122_3344);
    send_word(32'hFFFF_FFFF);
    idle();
    idle();
    #1;
    check("csum_state_check", 32'(st), 32'(S_CHECK));
    check("csum_busy_check", 32'(busy), 32'd1);
    send(8'h44);
    idle();
    wait_end("csum_ok");
    check("csum_ok_done", 32'(done), 32'd1);
    check("csum_ok_error", 32'(error), 32'd0);

    pulse_start();
    expect_write(32'd0, 32'h1122_3344);
    expect_write(32'd4, 32'hFFFF_FFFF);
    send_word(32'h1122_3344);
    send_word(32'hFFFF_FFFF);
    idle();
    idle();
    send(8'h45);
    idle();
    wait_end("csum_bad");
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_done", 32'(done), 32'd0);
`endif

    repeat (3) @(negedge clk);
    #1;
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
